// File: rtl/dispensador_ctrl.sv
// Round-robin controller for N_CH dispensers sharing one actuator supply:
// latches requests, drives one fixed-length pulse at a time, then a supply cooldown.
module dispensador_ctrl #(
    parameter int N_CH      = 4,
    parameter int PULSE_LEN = 8,
    parameter int COOL_LEN  = 4,
    parameter int IDX_W     = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   MC,
    input  logic [N_CH-1:0]   BZ,
    input  logic              alarm_clr,
    output logic [N_CH-1:0]   AD,
    output logic [N_CH-1:0]   A,
    output logic [N_CH-1:0]   pending,
    output logic              busy,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              done
);

    localparam int CMAX  = (PULSE_LEN > COOL_LEN) ? PULSE_LEN : COOL_LEN;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, COOL} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_rr, w_rr_nxt;
    logic [IDX_W-1:0]   r_gidx, w_gidx_nxt;
    logic [N_CH-1:0]    r_ad, w_ad_nxt;
    logic [N_CH-1:0]    r_alarm, w_alarm_nxt;
    logic [N_CH-1:0]    r_pend, w_pend_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;

    logic [N_CH-1:0]    w_cand;
    logic [N_CH-1:0]    w_grant;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_j;
    logic [IDX_W-1:0]   w_rr_after;

    assign w_cand     = r_pend & ~BZ;
    assign w_rr_after = (r_gidx == IDX_W'(N_CH - 1)) ? '0 : r_gidx + 1'b1;

    // Scan downward so the last hit is the first candidate at or after r_rr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_j     = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_j = IDX_W'((int'(r_rr) + k) % N_CH);
            if (w_cand[w_j]) begin
                w_found = 1'b1;
                w_pick  = w_j;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        w_gidx_nxt  = r_gidx;
        w_ad_nxt    = r_ad;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_grant     = '0;
        // BZ sets and wins over a simultaneous clear.
        w_alarm_nxt = (r_alarm & ~({N_CH{alarm_clr}} & ~BZ)) | BZ;
        w_pend_nxt  = (r_pend | (MC & ~r_alarm)) & ~BZ;

        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant     = N_CH'(1) << w_pick;
                    w_ad_nxt    = w_grant;
                    w_gidx_nxt  = w_pick;
                    w_cnt_nxt   = CNT_W'(PULSE_LEN - 1);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (BZ[r_gidx] || r_cnt == '0) begin
                    w_ad_nxt   = '0;
                    w_rr_nxt   = w_rr_after;
                    w_done_nxt = ~BZ[r_gidx];
                    if (COOL_LEN > 0) begin
                        w_cnt_nxt   = CNT_W'((COOL_LEN > 0) ? COOL_LEN - 1 : 0);
                        w_state_nxt = COOL;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            COOL: begin
                if (r_cnt == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A grant clears its request even if MC is still high this edge.
        w_pend_nxt = w_pend_nxt & ~w_grant;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rr    <= '0;
            r_gidx  <= '0;
            r_ad    <= '0;
            r_alarm <= '0;
            r_pend  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rr    <= w_rr_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ad    <= w_ad_nxt;
            r_alarm <= w_alarm_nxt;
            r_pend  <= w_pend_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign AD        = r_ad;
    assign A         = r_alarm;
    assign pending   = r_pend;
    assign busy      = r_busy;
    assign grant_idx = r_gidx;
    assign done      = r_done;

endmodule

// File: tb/tb_dispensador_ctrl.sv
// Bench for dispensador_ctrl (N_CH=4, PULSE_LEN=3, COOL_LEN=2): vector table,
// directed corner sequences and random traffic against a cycle-level reference model.
module tb_dispensador_ctrl;

    localparam int N = 4;
    localparam int P = 3;
    localparam int C = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] MC = '0, BZ = '0;
    logic       alarm_clr = 1'b0;
    logic [3:0] AD, A, pending;
    logic       busy, done;
    logic [1:0] grant_idx;

    dispensador_ctrl #(.N_CH(N), .PULSE_LEN(P), .COOL_LEN(C)) dut (
        .clk(clk), .reset(reset), .MC(MC), .BZ(BZ), .alarm_clr(alarm_clr),
        .AD(AD), .A(A), .pending(pending), .busy(busy),
        .grant_idx(grant_idx), .done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: which channel is firing, remaining pulse/cool cycles.
    int       m_ad_ch = -1;
    int       m_pulse = 0;
    int       m_cool  = 0;
    int       m_rr    = 0;
    int       m_gidx  = 0;
    bit [3:0] m_A     = '0;
    bit [3:0] m_pend  = '0;
    bit       m_done  = 0;
    bit       prev_done = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_step(input bit rst_n, input bit [3:0] mc, input bit [3:0] bz, input bit clr);
        int       granted;
        bit [3:0] oldA, oldP;
        if (!rst_n) begin
            m_ad_ch = -1; m_pulse = 0; m_cool = 0; m_rr = 0; m_gidx = 0;
            m_A = '0; m_pend = '0; m_done = 0;
            return;
        end
        granted = -1;
        m_done  = 0;
        oldA    = m_A;
        oldP    = m_pend;
        if (m_ad_ch >= 0) begin
            if (bz[m_ad_ch]) begin
                m_rr = (m_ad_ch + 1) % N; m_ad_ch = -1; m_cool = C;
            end else begin
                m_pulse--;
                if (m_pulse == 0) begin
                    m_done = 1; m_rr = (m_ad_ch + 1) % N; m_ad_ch = -1; m_cool = C;
                end
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (granted < 0 && oldP[j] && !bz[j]) granted = j;
            end
            if (granted >= 0) begin
                m_ad_ch = granted; m_pulse = P; m_gidx = granted;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bz[i]) m_A[i] = 1;
            else if (clr) m_A[i] = 0;
            if (bz[i] || i == granted) m_pend[i] = 0;
            else if (mc[i] && !oldA[i]) m_pend[i] = 1;
        end
    endtask

    function automatic int m_ad_vec();
        return (m_ad_ch >= 0) ? (1 << m_ad_ch) : 0;
    endfunction

    task automatic step(input bit rst_n, input bit [3:0] mc, input bit [3:0] bz, input bit clr);
        @(negedge clk);
        reset = rst_n; MC = mc; BZ = bz; alarm_clr = clr;
        @(posedge clk);
        model_step(rst_n, mc, bz, clr);
        #1;
        chk("model_AD", AD, m_ad_vec());
        chk("model_A", A, m_A);
        chk("model_pending", pending, m_pend);
        chk("model_busy", busy, int'(m_ad_ch >= 0 || m_cool > 0));
        chk("model_done", done, m_done);
        chk("model_gidx", grant_idx, m_gidx);
        chk("inv_onehot0", int'($onehot0(AD)), 1);
        chk("inv_ad_and_a", AD & A, 0);
        chk("inv_done_twice", int'(done && prev_done), 0);
        prev_done = done;
    endtask

    typedef struct {
        bit       rst; bit [3:0] mc; bit [3:0] bz; bit clr;
        bit [3:0] ad;  bit [3:0] a;  bit [3:0] pend; bit busy; bit done; bit [1:0] gidx;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, input bit [3:0] mc, input bit [3:0] ad,
                       input bit [3:0] pend, input bit b, input bit d, input bit [1:0] g);
        vec_t v;
        v.rst = rst; v.mc = mc; v.bz = '0; v.clr = 0;
        v.ad = ad; v.a = '0; v.pend = pend; v.busy = b; v.done = d; v.gidx = g;
        tbl.push_back(v);
    endtask

    initial begin
        int       cyc, last_rise, rises, got;
        bit [3:0] prev_ad;

        // Single request on channel 2 after a 2-cycle reset.
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 4'b0100, 4'b0000, 4'b0100, 0, 0, 0);
        add(1, 4'b0000, 4'b0100, 4'b0000, 1, 0, 2);
        add(1, 4'b0000, 4'b0100, 4'b0000, 1, 0, 2);
        add(1, 4'b0000, 4'b0100, 4'b0000, 1, 0, 2);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2);
        // Three requests at once from rr_ptr=0: served 0,1,3.
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 4'b1011, 4'b0000, 4'b1011, 0, 0, 0);
        add(1, 4'b0000, 4'b0001, 4'b1010, 1, 0, 0);
        add(1, 4'b0000, 4'b0001, 4'b1010, 1, 0, 0);
        add(1, 4'b0000, 4'b0001, 4'b1010, 1, 0, 0);
        add(1, 4'b0000, 4'b0000, 4'b1010, 1, 1, 0);
        add(1, 4'b0000, 4'b0000, 4'b1010, 1, 0, 0);
        add(1, 4'b0000, 4'b0000, 4'b1010, 0, 0, 0);
        add(1, 4'b0000, 4'b0010, 4'b1000, 1, 0, 1);
        add(1, 4'b0000, 4'b0010, 4'b1000, 1, 0, 1);
        add(1, 4'b0000, 4'b0010, 4'b1000, 1, 0, 1);
        add(1, 4'b0000, 4'b0000, 4'b1000, 1, 1, 1);
        add(1, 4'b0000, 4'b0000, 4'b1000, 1, 0, 1);
        add(1, 4'b0000, 4'b0000, 4'b1000, 0, 0, 1);
        add(1, 4'b0000, 4'b1000, 4'b0000, 1, 0, 3);
        add(1, 4'b0000, 4'b1000, 4'b0000, 1, 0, 3);
        add(1, 4'b0000, 4'b1000, 4'b0000, 1, 0, 3);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 3);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 3);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 3);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].mc, tbl[i].bz, tbl[i].clr);
            chk($sformatf("tbl%0d_AD", i), AD, tbl[i].ad);
            chk($sformatf("tbl%0d_A", i), A, tbl[i].a);
            chk($sformatf("tbl%0d_pend", i), pending, tbl[i].pend);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            chk($sformatf("tbl%0d_gidx", i), grant_idx, tbl[i].gidx);
        end

        // Abort: BZ on the granted channel during its 2nd pulse cycle.
        step(0, 0, 0, 0);
        step(1, 4'b0010, 0, 0);
        step(1, 0, 0, 0);
        chk("s3_granted", AD, 4'b0010);
        step(1, 0, 0, 0);
        step(1, 0, 4'b0010, 0);
        chk("s3_abort_AD", AD, 0);
        chk("s3_abort_A", A, 4'b0010);
        chk("s3_abort_done", done, 0);
        chk("s3_abort_busy", busy, 1);
        got = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0010, 0, 0);
            got = got | pending[1] | done | AD[1];
        end
        chk("s3_mc_ignored", got, 0);

        // Clear vs. active BZ, then a real clear and service.
        step(1, 0, 4'b0010, 1);
        chk("s4_bz_wins", A, 4'b0010);
        step(1, 0, 0, 1);
        chk("s4_cleared", A, 0);
        step(1, 4'b0010, 0, 0);
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step(1, 0, 0, 0);
            if (AD == 4'b0010) got = 1;
        end
        chk("s4_served", got, 1);

        // Reset mid-pulse with another request pending.
        step(0, 0, 0, 0);
        step(1, 4'b0001, 0, 0);
        step(1, 4'b1000, 0, 0);
        step(1, 0, 0, 0);
        chk("s5_pre_pend", pending, 4'b1000);
        chk("s5_pre_AD", AD, 4'b0001);
        step(0, 0, 0, 0);
        chk("s5_rst_AD", AD, 0);
        chk("s5_rst_pend", pending, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_A", A, 0);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
            got = got | int'(AD != 0) | done;
        end
        chk("s5_no_resume", got, 0);

        // MC[0] held high: re-grant every P+C+1 cycles.
        step(0, 0, 0, 0);
        rises = 0; last_rise = -1; prev_ad = '0;
        for (cyc = 0; cyc < 20; cyc++) begin
            step(1, 4'b0001, 0, 0);
            if (AD[0] && !prev_ad[0]) begin
                if (last_rise >= 0) chk("s6_spacing", cyc - last_rise, P + C + 1);
                last_rise = cyc;
                rises++;
            end
            prev_ad = AD;
        end
        chk("s6_rises", rises, 4);

        // Random traffic.
        step(0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit [3:0] bz;
            for (int b = 0; b < N; b++) bz[b] = ($urandom_range(0, 11) == 0);
            step($urandom_range(0, 99) != 0, 4'($urandom), bz, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
